// File: rtl/alu_operand_stage_if.sv
// Bundle between the ID stage, the forwarding sources and the EX-stage ALU operands.
// The master drives decoded fields and forwarding; the slave is the operand stage.
interface alu_operand_stage_if #(
  parameter int unsigned ALUOP_W = 4
);
  logic               flush;
  logic               hold;
  logic [31:0]        id_rs_val;
  logic [31:0]        id_rt_val;
  logic [4:0]         id_rs;
  logic [4:0]         id_rt;
  logic               id_use_rs;
  logic               id_use_rt;
  logic [15:0]        id_imm;
  logic               id_imm_zext;
  logic [4:0]         id_shamt;
  logic               id_sel_a_shamt;
  logic               id_sel_b_imm;
  logic [ALUOP_W-1:0] id_aluop;
  logic [4:0]         id_wr_addr;
  logic               id_reg_write;
  logic               id_mem_read;
  logic               id_mem_write;
  logic               mem_fwd_en;
  logic [4:0]         mem_fwd_addr;
  logic [31:0]        mem_fwd_data;
  logic               wb_fwd_en;
  logic [4:0]         wb_fwd_addr;
  logic [31:0]        wb_fwd_data;
  logic               stall_out;
  logic [31:0]        ex_A;
  logic [31:0]        ex_B;
  logic [ALUOP_W-1:0] ex_aluop;
  logic [31:0]        ex_store_data;
  logic [4:0]         ex_wr_addr;
  logic               ex_reg_write;
  logic               ex_mem_read;
  logic               ex_mem_write;
  logic               ex_valid;

  modport master (
    output flush, hold, id_rs_val, id_rt_val, id_rs, id_rt, id_use_rs, id_use_rt, id_imm,
           id_imm_zext, id_shamt, id_sel_a_shamt, id_sel_b_imm, id_aluop, id_wr_addr,
           id_reg_write, id_mem_read, id_mem_write, mem_fwd_en, mem_fwd_addr, mem_fwd_data,
           wb_fwd_en, wb_fwd_addr, wb_fwd_data,
    input  stall_out, ex_A, ex_B, ex_aluop, ex_store_data, ex_wr_addr, ex_reg_write,
           ex_mem_read, ex_mem_write, ex_valid
  );

  modport slave (
    input  flush, hold, id_rs_val, id_rt_val, id_rs, id_rt, id_use_rs, id_use_rt, id_imm,
           id_imm_zext, id_shamt, id_sel_a_shamt, id_sel_b_imm, id_aluop, id_wr_addr,
           id_reg_write, id_mem_read, id_mem_write, mem_fwd_en, mem_fwd_addr, mem_fwd_data,
           wb_fwd_en, wb_fwd_addr, wb_fwd_data,
    output stall_out, ex_A, ex_B, ex_aluop, ex_store_data, ex_wr_addr, ex_reg_write,
           ex_mem_read, ex_mem_write, ex_valid
  );
endinterface

// File: rtl/alu_operand_stage.sv
// ID/EX pipeline register with MEM/WB operand forwarding, load-use stall detection,
// flush and external hold. Feeds the ALU A/B/ALUop inputs directly.
module alu_operand_stage #(
  parameter int unsigned        ALUOP_W   = 4,
  parameter logic [ALUOP_W-1:0] BUBBLE_OP = '1
) (
  input logic                clk,
  input logic                rst,
  alu_operand_stage_if.slave bus
);

  logic               valid_q;
  logic               reg_write_q;
  logic               mem_read_q;
  logic               mem_write_q;
  logic               sel_a_q;
  logic               sel_b_q;
  logic [31:0]        rs_val_q;
  logic [31:0]        rt_val_q;
  logic [31:0]        imm32_q;
  logic [4:0]         rs_q;
  logic [4:0]         rt_q;
  logic [4:0]         shamt_q;
  logic [4:0]         wr_addr_q;
  logic [ALUOP_W-1:0] aluop_q;

  logic        rs_hit;
  logic        rt_hit;
  logic        haz;
  logic        upd;
  logic        clr;
  logic [31:0] imm32;
  logic [31:0] fwd_rs;
  logic [31:0] fwd_rt;

  assign rs_hit = bus.id_use_rs && (bus.id_rs == wr_addr_q);
  assign rt_hit = bus.id_use_rt && (bus.id_rt == wr_addr_q);
  assign haz    = valid_q && mem_read_q && (wr_addr_q != 5'd0) && (rs_hit || rt_hit);

  assign bus.stall_out = haz && !bus.flush;

  assign imm32 = bus.id_imm_zext ? {16'b0, bus.id_imm} : {{16{bus.id_imm[15]}}, bus.id_imm};

  // Reset and flush always update; hold freezes everything else, including hazard bubbles.
  assign upd = rst || bus.flush || !bus.hold;
  assign clr = rst || bus.flush || haz;

  always_ff @(posedge clk) begin
    if (upd) begin
      if (clr) begin
        valid_q     <= 1'b0;
        reg_write_q <= 1'b0;
        mem_read_q  <= 1'b0;
        mem_write_q <= 1'b0;
        sel_a_q     <= 1'b0;
        sel_b_q     <= 1'b0;
        rs_val_q    <= '0;
        rt_val_q    <= '0;
        imm32_q     <= '0;
        rs_q        <= '0;
        rt_q        <= '0;
        shamt_q     <= '0;
        wr_addr_q   <= '0;
        aluop_q     <= BUBBLE_OP;
      end else begin
        valid_q     <= 1'b1;
        reg_write_q <= bus.id_reg_write;
        mem_read_q  <= bus.id_mem_read;
        mem_write_q <= bus.id_mem_write;
        sel_a_q     <= bus.id_sel_a_shamt;
        sel_b_q     <= bus.id_sel_b_imm;
        rs_val_q    <= bus.id_rs_val;
        rt_val_q    <= bus.id_rt_val;
        imm32_q     <= imm32;
        rs_q        <= bus.id_rs;
        rt_q        <= bus.id_rt;
        shamt_q     <= bus.id_shamt;
        wr_addr_q   <= bus.id_wr_addr;
        aluop_q     <= bus.id_aluop;
      end
    end
  end

  // MEM is the younger producer, so it wins over WB; $0 is hard-wired and never forwarded.
  function automatic logic [31:0] resolve(input logic [4:0]  addr,
                                          input logic [31:0] regval,
                                          input logic        mem_en,
                                          input logic [4:0]  mem_addr,
                                          input logic [31:0] mem_data,
                                          input logic        wb_en,
                                          input logic [4:0]  wb_addr,
                                          input logic [31:0] wb_data);
    logic [31:0] r;
    r = regval;
    if (mem_en && (mem_addr != 5'd0) && (mem_addr == addr)) begin
      r = mem_data;
    end else if (wb_en && (wb_addr != 5'd0) && (wb_addr == addr)) begin
      r = wb_data;
    end
    return r;
  endfunction

  always_comb begin
    fwd_rs = resolve(rs_q, rs_val_q, bus.mem_fwd_en, bus.mem_fwd_addr, bus.mem_fwd_data,
                     bus.wb_fwd_en, bus.wb_fwd_addr, bus.wb_fwd_data);
    fwd_rt = resolve(rt_q, rt_val_q, bus.mem_fwd_en, bus.mem_fwd_addr, bus.mem_fwd_data,
                     bus.wb_fwd_en, bus.wb_fwd_addr, bus.wb_fwd_data);
  end

  assign bus.ex_A          = sel_a_q ? {27'b0, shamt_q} : fwd_rs;
  assign bus.ex_B          = sel_b_q ? imm32_q : fwd_rt;
  assign bus.ex_store_data = fwd_rt;
  assign bus.ex_aluop      = aluop_q;
  assign bus.ex_wr_addr    = wr_addr_q;
  assign bus.ex_reg_write  = reg_write_q;
  assign bus.ex_mem_read   = mem_read_q;
  assign bus.ex_mem_write  = mem_write_q;
  assign bus.ex_valid      = valid_q;

endmodule

// File: tb/tb_alu_operand_stage.sv
// Directed bench for alu_operand_stage: stimulus pushes hand-computed expectations into a
// queue, and a negedge monitor pops one per cycle and compares against the DUT outputs.
module tb_alu_operand_stage;

  localparam logic [3:0] BUB  = 4'hF;
  localparam logic [3:0] ADDU = 4'd1;
  localparam logic [3:0] SLL  = 4'd2;

  typedef struct {
    int          step;
    logic        has_dat;
    logic        stall;
    logic        valid;
    logic        rw;
    logic        mr;
    logic        mw;
    logic [3:0]  op;
    logic [4:0]  wa;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] sd;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  int   nvec = 0;
  int   nerr = 0;
  int   step = 0;
  exp_t q[$];
  exp_t cur;
  exp_t mon;

  always #5 clk = ~clk;

  alu_operand_stage_if #(.ALUOP_W(4)) bus ();

  alu_operand_stage #(
    .ALUOP_W  (4),
    .BUBBLE_OP(BUB)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  task automatic cmp(input int st, input string f, input logic [31:0] act,
                     input logic [31:0] expv);
    nvec++;
    if (act !== expv) begin
      nerr++;
      $display("FAIL step %0d %s: got 0x%08h, expected 0x%08h", st, f, act, expv);
    end
  endtask

  // Monitor: one expectation per cycle, checked mid-cycle once combinational paths settle.
  always @(negedge clk) begin
    if (q.size() != 0) begin
      mon = q.pop_front();
      cmp(mon.step, "stall_out", 32'(bus.stall_out), 32'(mon.stall));
      cmp(mon.step, "ex_valid", 32'(bus.ex_valid), 32'(mon.valid));
      cmp(mon.step, "ex_reg_write", 32'(bus.ex_reg_write), 32'(mon.rw));
      cmp(mon.step, "ex_mem_read", 32'(bus.ex_mem_read), 32'(mon.mr));
      cmp(mon.step, "ex_mem_write", 32'(bus.ex_mem_write), 32'(mon.mw));
      cmp(mon.step, "ex_aluop", 32'(bus.ex_aluop), 32'(mon.op));
      cmp(mon.step, "ex_wr_addr", 32'(bus.ex_wr_addr), 32'(mon.wa));
      if (mon.has_dat) begin
        cmp(mon.step, "ex_A", bus.ex_A, mon.a);
        cmp(mon.step, "ex_B", bus.ex_B, mon.b);
        cmp(mon.step, "ex_store_data", bus.ex_store_data, mon.sd);
      end
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic exp_ctl(input logic [31:0] stall, valid, rw, mr, mw, input logic [3:0] op,
                         input logic [31:0] wa);
    cur.step    = step;
    cur.has_dat = 1'b0;
    cur.stall   = stall[0];
    cur.valid   = valid[0];
    cur.rw      = rw[0];
    cur.mr      = mr[0];
    cur.mw      = mw[0];
    cur.op      = op;
    cur.wa      = wa[4:0];
    cur.a       = '0;
    cur.b       = '0;
    cur.sd      = '0;
  endtask

  task automatic exp_dat(input logic [31:0] a, b, sd);
    cur.has_dat = 1'b1;
    cur.a       = a;
    cur.b       = b;
    cur.sd      = sd;
  endtask

  task automatic push;
    q.push_back(cur);
    step++;
  endtask

  task automatic set_instr(input logic [31:0] rsv, rtv, rs, rt, use_rs, use_rt,
                           input logic [3:0] op, input logic [31:0] wr, rw, mr, mw);
    bus.id_rs_val      = rsv;
    bus.id_rt_val      = rtv;
    bus.id_rs          = rs[4:0];
    bus.id_rt          = rt[4:0];
    bus.id_use_rs      = use_rs[0];
    bus.id_use_rt      = use_rt[0];
    bus.id_aluop       = op;
    bus.id_wr_addr     = wr[4:0];
    bus.id_reg_write   = rw[0];
    bus.id_mem_read    = mr[0];
    bus.id_mem_write   = mw[0];
    bus.id_imm         = 16'h0;
    bus.id_imm_zext    = 1'b0;
    bus.id_shamt       = 5'd0;
    bus.id_sel_a_shamt = 1'b0;
    bus.id_sel_b_imm   = 1'b0;
  endtask

  task automatic set_mem(input logic en, input logic [4:0] addr, input logic [31:0] data);
    bus.mem_fwd_en   = en;
    bus.mem_fwd_addr = addr;
    bus.mem_fwd_data = data;
  endtask

  task automatic set_wb(input logic en, input logic [4:0] addr, input logic [31:0] data);
    bus.wb_fwd_en   = en;
    bus.wb_fwd_addr = addr;
    bus.wb_fwd_data = data;
  endtask

  initial begin
    rst       = 1'b1;
    bus.flush = 1'b0;
    bus.hold  = 1'b0;
    set_mem(1'b0, 5'd0, 32'h0);
    set_wb(1'b0, 5'd0, 32'h0);
    set_instr(0, 0, 0, 0, 0, 0, 4'd0, 0, 0, 0, 0);
    tick;
    tick;
    rst = 1'b0;

    // Reset state; ADDU presented at ID.
    set_instr(5, 7, 1, 2, 1, 1, ADDU, 3, 1, 0, 0);
    exp_ctl(0, 0, 0, 0, 0, BUB, 0); exp_dat(0, 0, 0); push;
    tick;
    set_instr(32'hAAAA, 32'h55, 3, 4, 1, 1, ADDU, 5, 1, 0, 0);
    exp_ctl(0, 1, 1, 0, 0, ADDU, 3); exp_dat(5, 7, 7); push;
    tick;
    // Forward priority under hold (three held edges).
    bus.hold = 1'b1;
    set_mem(1'b1, 5'd3, 32'h11);
    set_wb(1'b1, 5'd3, 32'h22);
    exp_ctl(0, 1, 1, 0, 0, ADDU, 5); exp_dat(32'h11, 32'h55, 32'h55); push;
    tick;
    bus.mem_fwd_en = 1'b0;
    exp_ctl(0, 1, 1, 0, 0, ADDU, 5); exp_dat(32'h22, 32'h55, 32'h55); push;
    tick;
    set_mem(1'b1, 5'd4, 32'h44);
    exp_ctl(0, 1, 1, 0, 0, ADDU, 5); exp_dat(32'h22, 32'h44, 32'h44); push;
    tick;
    bus.hold = 1'b0;
    set_mem(1'b1, 5'd0, 32'h11);
    set_wb(1'b1, 5'd0, 32'h22);
    set_instr(32'h77, 32'h88, 0, 0, 1, 1, ADDU, 6, 1, 0, 0);
    exp_ctl(0, 1, 1, 0, 0, ADDU, 5); exp_dat(32'hAAAA, 32'h55, 32'h55); push;
    tick;
    // Registered $0 with forwarding aimed at $0 still enabled.
    exp_ctl(0, 1, 1, 0, 0, ADDU, 6); exp_dat(32'h77, 32'h88, 32'h88); push;
    set_mem(1'b0, 5'd0, 32'h0);
    set_wb(1'b0, 5'd0, 32'h0);
    set_instr(32'h10, 32'h99, 7, 9, 1, 0, ADDU, 8, 1, 0, 0);
    bus.id_sel_b_imm = 1'b1;
    bus.id_imm       = 16'h8000;
    tick;
    bus.id_imm_zext = 1'b1;
    exp_ctl(0, 1, 1, 0, 0, ADDU, 8); exp_dat(32'h10, 32'hFFFF8000, 32'h99); push;
    tick;
    set_instr(32'h1234, 5, 0, 9, 0, 1, SLL, 10, 1, 0, 0);
    bus.id_sel_a_shamt = 1'b1;
    bus.id_shamt       = 5'd31;
    exp_ctl(0, 1, 1, 0, 0, ADDU, 8); exp_dat(32'h10, 32'h8000, 32'h99); push;
    tick;
    set_instr(32'h100, 0, 1, 0, 1, 0, ADDU, 4, 1, 1, 0);
    bus.id_sel_b_imm = 1'b1;
    bus.id_imm       = 16'h0004;
    exp_ctl(0, 1, 1, 0, 0, SLL, 10); exp_dat(31, 5, 5); push;
    tick;
    // Load-use on rs: one stall, one bubble, then the consumer loads with WB forwarding.
    set_instr(0, 3, 4, 2, 1, 1, ADDU, 5, 1, 0, 0);
    exp_ctl(1, 1, 1, 1, 0, ADDU, 4); exp_dat(32'h100, 4, 0); push;
    tick;
    exp_ctl(0, 0, 0, 0, 0, BUB, 0); push;
    tick;
    set_wb(1'b1, 5'd4, 32'hCAFE);
    set_instr(32'h200, 0, 0, 0, 1, 0, ADDU, 6, 1, 1, 0);
    bus.id_sel_b_imm = 1'b1;
    bus.id_imm       = 16'h0008;
    exp_ctl(0, 1, 1, 0, 0, ADDU, 5); exp_dat(32'hCAFE, 3, 3); push;
    tick;
    // Matching rs address but use_rs=0: no stall. Consumer is a store.
    set_wb(1'b0, 5'd0, 32'h0);
    set_instr(32'h66, 32'h5A, 6, 0, 0, 0, ADDU, 7, 0, 0, 1);
    exp_ctl(0, 1, 1, 1, 0, ADDU, 6); exp_dat(32'h200, 8, 0); push;
    tick;
    set_instr(32'h300, 0, 0, 0, 1, 0, ADDU, 9, 1, 1, 0);
    bus.id_sel_b_imm = 1'b1;
    bus.id_imm       = 16'h000C;
    exp_ctl(0, 1, 0, 0, 1, ADDU, 7); exp_dat(32'h66, 32'h5A, 32'h5A); push;
    tick;
    // Flush with an rt load-use hazard pending: flush wins.
    set_instr(1, 0, 0, 9, 1, 1, ADDU, 11, 1, 0, 0);
    bus.flush = 1'b1;
    exp_ctl(0, 1, 1, 1, 0, ADDU, 9); exp_dat(32'h300, 32'hC, 0); push;
    tick;
    bus.flush = 1'b0;
    exp_ctl(0, 0, 0, 0, 0, BUB, 0); push;
    tick;
    set_instr(32'h400, 0, 0, 0, 1, 0, ADDU, 12, 1, 1, 0);
    bus.id_sel_b_imm = 1'b1;
    bus.id_imm       = 16'h0010;
    exp_ctl(0, 1, 1, 0, 0, ADDU, 11); exp_dat(1, 0, 0); push;
    tick;
    // Hold with hazard: contents frozen, stall still reported; then reset mid-stall.
    set_instr(0, 0, 12, 0, 1, 0, ADDU, 13, 1, 0, 0);
    bus.hold = 1'b1;
    exp_ctl(1, 1, 1, 1, 0, ADDU, 12); exp_dat(32'h400, 32'h10, 0); push;
    tick;
    bus.hold = 1'b0;
    rst      = 1'b1;
    exp_ctl(1, 1, 1, 1, 0, ADDU, 12); exp_dat(32'h400, 32'h10, 0); push;
    tick;
    rst = 1'b0;
    exp_ctl(0, 0, 0, 0, 0, BUB, 0); exp_dat(0, 0, 0); push;
    tick;
    exp_ctl(0, 1, 1, 0, 0, ADDU, 13); exp_dat(0, 0, 0); push;

    for (int i = 0; i < 20 && q.size() != 0; i++) begin
      @(negedge clk);
      #1;
    end
    if (q.size() != 0) begin
      nerr++;
      $display("FAIL drain: %0d expectations left, expected 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/alu_operand_stage.md
Name: alu_operand_stage

Overview:
ID/EX pipeline register and operand-forwarding stage that directly feeds the 32-bit ALU's A, B and ALUop inputs. It registers the decoded instruction and resolves RAW hazards by forwarding from the MEM and WB stages. It detects load-use hazards, requests a one-cycle upstream stall and injects a bubble. It also supports flush (taken branch/jump) and an external hold.

Parameters:
- ALUOP_W, 4, width of ALU operation code (encodings per ALUop.vh)
- BUBBLE_OP, `ALU_XXX, ALUop driven for a bubble or after reset

Ports:
- clk  in  1  system clock, all state updates on rising edge
- rst  in  1  synchronous active-high reset
- flush  in  1  squash instruction entering EX (taken branch/jump)
- hold  in  1  external stall (memory wait); freeze stage contents
- id_rs_val  in  32  register-file read of rs
- id_rt_val  in  32  register-file read of rt
- id_rs  in  5  rs address
- id_rt  in  5  rt address
- id_use_rs  in  1  instruction reads rs
- id_use_rt  in  1  instruction reads rt
- id_imm  in  16  raw immediate
- id_imm_zext  in  1  1 = zero-extend immediate, 0 = sign-extend
- id_shamt  in  5  shift amount field
- id_sel_a_shamt  in  1  A operand = zero-extended shamt instead of rs
- id_sel_b_imm  in  1  B operand = extended immediate instead of rt
- id_aluop  in  ALUOP_W  ALU operation
- id_wr_addr  in  5  destination register
- id_reg_write  in  1  instruction writes the register file
- id_mem_read  in  1  load
- id_mem_write  in  1  store
- mem_fwd_en  in  1  MEM stage will write a register
- mem_fwd_addr  in  5  MEM stage destination
- mem_fwd_data  in  32  MEM stage ALU result
- wb_fwd_en  in  1  WB stage writes a register
- wb_fwd_addr  in  5  WB destination
- wb_fwd_data  in  32  WB write data
- stall_out  out  1  load-use hazard; IF/ID must hold this cycle
- ex_A  out  32  ALU A operand
- ex_B  out  32  ALU B operand
- ex_aluop  out  ALUOP_W  ALU operation
- ex_store_data  out  32  forwarded rt value for stores
- ex_wr_addr  out  5  registered destination
- ex_reg_write  out  1  registered write enable (0 for bubble)
- ex_mem_read  out  1  registered load flag
- ex_mem_write  out  1  registered store flag
- ex_valid  out  1  stage holds a real instruction

Behaviour:
- Reset (rst=1 at edge): all stage registers cleared. ex_valid, ex_reg_write, ex_mem_read, ex_mem_write = 0; ex_aluop = BUBBLE_OP; ex_wr_addr = 0; ex_A = ex_B = ex_store_data = 0 (absent forwarding matches); stall_out = 0.
- Hazard (combinational): haz = ex_valid & ex_mem_read & (ex_wr_addr != 0) & ((id_use_rs & id_rs == ex_wr_addr) | (id_use_rt & id_rt == ex_wr_addr)). stall_out = haz & ~flush.
- Register update priority per edge: rst > flush (load bubble) > hold (keep all contents) > haz (load bubble) > load id_* fields with ex_valid = 1.
- Bubble: valid, reg_write, mem_read and mem_write = 0; aluop = BUBBLE_OP; wr_addr = 0.
- Immediate: imm32 = id_imm_zext ? {16'b0, imm} : {{16{imm[15]}}, imm}. Extension happens at load time; the ALU takes B[15:0] for LUI.
- Forwarding (combinational, from registered rs/rt addresses):
  - fwd_rs = mem_fwd_data if mem_fwd_en & mem_fwd_addr != 0 & mem_fwd_addr == rs.
  - Otherwise fwd_rs = wb_fwd_data if wb_fwd_en & wb_fwd_addr != 0 & wb_fwd_addr == rs.
  - Otherwise fwd_rs = the registered rs_val. fwd_rt is resolved the same way.
  - MEM has priority over WB. $0 is never forwarded.
- ex_A = sel_a_shamt ? {27'b0, shamt} : fwd_rs. ex_B = sel_b_imm ? imm32 : fwd_rt. ex_store_data = fwd_rt.
- Latency: one cycle from id_* to ex_* registered outputs. Forwarding paths are zero-latency.
- Simultaneous flush and haz: flush wins; stall_out = 0 and a bubble is loaded.
- hold with haz: contents held; stall_out still reports haz.
- rst mid-stall: the next cycle is a reset bubble and stall_out deasserts.

Test Plan:
- Reset: rst=1 for 2 cycles, then 0 with no load -> ex_valid=0, ex_aluop=BUBBLE_OP, ex_A=ex_B=0, stall_out=0.
- Plain ADDU: rs_val=5, rt_val=7, aluop=ADDU, load -> next cycle ex_A=5, ex_B=7, ex_reg_write=1, ex_valid=1.
- Forward priority: registered rs=$3; mem_fwd (en, $3, 0x11) and wb_fwd (en, $3, 0x22) both active -> ex_A=0x11. Drop mem_fwd_en -> ex_A=0x22. With addr=$0 -> registered value used.
- Immediate/shamt: imm=0x8000, zext=0, sel_b_imm -> ex_B=0xFFFF8000; zext=1 -> 0x00008000. sel_a_shamt with shamt=31 -> ex_A=31.
- Load-use: LW $4 in EX, next ID instruction uses rs=$4 -> stall_out=1 for exactly one cycle, bubble loaded (ex_reg_write=0), then the instruction loads. Same with use_rs=0 -> no stall.
- Flush/hold: flush with haz active -> stall_out=0, bubble loaded. hold=1 for 3 cycles -> ex_* registered outputs unchanged.
